// File: rtl/immgen_stage.sv
// Decode-path immediate generator: classifies the instruction format, builds the
// sign/zero-extended immediate and pc+imm, and holds results in a two-entry
// (main + skid) output buffer so one cycle of downstream stall loses no beat.
module immgen_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           inst,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic [DATA_WIDTH-1:0] out_target,
    output logic [2:0]            out_fmt,
    output logic [31:0]           out_inst
);

    generate
        if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
            $error("immgen_stage: DATA_WIDTH must be 32 or 64");
        end
    endgenerate

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    localparam bit IS_RV64 = (DATA_WIDTH == 64);

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [2:0]            dec_fmt;
    logic [31:0]           imm32;
    logic [5:0]            shamt;
    logic                  is_shift;
    logic [DATA_WIDTH-1:0] dec_imm;
    logic [DATA_WIDTH-1:0] dec_target;

    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_imm;
    logic [DATA_WIDTH-1:0] skid_target;
    logic [2:0]            skid_fmt;
    logic [31:0]           skid_inst;

    logic                  accept;
    logic                  xfer;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];

    // Format classification and immediate construction from the incoming word.
    always_comb begin
        dec_fmt  = FMT_ILL;
        imm32    = '0;
        shamt    = '0;
        is_shift = 1'b0;

        case (opcode)
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: dec_fmt = FMT_I;
            7'b0011011: dec_fmt = IS_RV64 ? FMT_I : FMT_ILL;
            7'b0100011: dec_fmt = FMT_S;
            7'b1100011: dec_fmt = FMT_B;
            7'b0110111, 7'b0010111: dec_fmt = FMT_U;
            7'b1101111: dec_fmt = FMT_J;
            7'b0110011: dec_fmt = FMT_R;
            7'b0111011: dec_fmt = IS_RV64 ? FMT_R : FMT_ILL;
            default:    dec_fmt = FMT_ILL;
        endcase

        case (dec_fmt)
            FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm32 = {inst[31:12], 12'b0};
            FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase

        // Shifts carry a zero-extended shamt; funct7 never leaks into the immediate.
        if ((funct3 == 3'b001 || funct3 == 3'b101) &&
            (opcode == 7'b0010011 || (opcode == 7'b0011011 && IS_RV64))) begin
            is_shift = 1'b1;
        end
        if (opcode == 7'b0010011 && IS_RV64) begin
            shamt = inst[25:20];
        end else begin
            shamt = {1'b0, inst[24:20]};
        end

        dec_imm       = {DATA_WIDTH{imm32[31]}};
        dec_imm[31:0] = imm32;
        if (is_shift) begin
            dec_imm      = '0;
            dec_imm[5:0] = shamt;
        end
    end

    assign dec_target = pc + dec_imm;

    assign accept = in_valid && in_ready;
    assign xfer   = out_valid && out_ready;

    // Main/skid buffer: main feeds the outputs, skid catches the beat accepted during a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
            out_imm     <= '0;
            out_target  <= '0;
            out_fmt     <= '0;
            out_inst    <= '0;
            skid_valid  <= 1'b0;
            skid_imm    <= '0;
            skid_target <= '0;
            skid_fmt    <= '0;
            skid_inst   <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (!out_valid || xfer) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_imm    <= skid_imm;
                out_target <= skid_target;
                out_fmt    <= skid_fmt;
                out_inst   <= skid_inst;
                if (accept) begin
                    skid_imm    <= dec_imm;
                    skid_target <= dec_target;
                    skid_fmt    <= dec_fmt;
                    skid_inst   <= inst;
                    in_ready    <= 1'b0;
                end else begin
                    skid_valid <= 1'b0;
                    in_ready   <= 1'b1;
                end
            end else begin
                out_valid <= accept;
                in_ready  <= 1'b1;
                if (accept) begin
                    out_imm    <= dec_imm;
                    out_target <= dec_target;
                    out_fmt    <= dec_fmt;
                    out_inst   <= inst;
                end
            end
        end else if (accept) begin
            skid_valid  <= 1'b1;
            skid_imm    <= dec_imm;
            skid_target <= dec_target;
            skid_fmt    <= dec_fmt;
            skid_inst   <= inst;
            in_ready    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_immgen_stage.sv
// Bench for immgen_stage: RV32 and RV64 instances share one handshake stream and
// are compared against an arithmetic reference model and a FIFO scoreboard.
module tb_immgen_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] inst;
    logic [63:0] pc;

    logic        in_ready32, out_valid32;
    logic [31:0] out_imm32, out_target32, out_inst32;
    logic [2:0]  out_fmt32;
    logic        in_ready64, out_valid64;
    logic [63:0] out_imm64, out_target64;
    logic [31:0] out_inst64;
    logic [2:0]  out_fmt64;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } beat_t;

    beat_t q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    immgen_stage #(.DATA_WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .inst(inst), .pc(pc[31:0]),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_target(out_target32),
        .out_fmt(out_fmt32), .out_inst(out_inst32)
    );

    immgen_stage #(.DATA_WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .inst(inst), .pc(pc),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_target(out_target64),
        .out_fmt(out_fmt64), .out_inst(out_inst64)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [2:0] ref_fmt(input logic [31:0] i, input bit is64);
        case (i[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: return 3'd1;
            7'h1B:        return is64 ? 3'd1 : 3'd7;
            7'h23:        return 3'd2;
            7'h63:        return 3'd3;
            7'h37, 7'h17: return 3'd4;
            7'h6F:        return 3'd5;
            7'h33:        return 3'd0;
            7'h3B:        return is64 ? 3'd0 : 3'd7;
            default:      return 3'd7;
        endcase
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] i, input bit is64);
        int     s   = int'(i);
        longint v   = 0;
        bit     sft = (i[14:12] == 3'd1 || i[14:12] == 3'd5);
        case (ref_fmt(i, is64))
            3'd1: v = longint'(s >>> 20);
            3'd2: v = longint'(((s >>> 20) & -32) | int'({27'b0, i[11:7]}));
            3'd3: v = (longint'(i[11:8]) << 1) + (longint'(i[30:25]) << 5)
                      + (longint'(i[7]) << 11) - (longint'(i[31]) << 12);
            3'd4: v = longint'(int'(i & 32'hFFFFF000));
            3'd5: v = (longint'(i[30:21]) << 1) + (longint'(i[20]) << 11)
                      + (longint'(i[19:12]) << 12) - (longint'(i[31]) << 20);
            default: v = 0;
        endcase
        if (sft && i[6:0] == 7'h13) v = is64 ? longint'(i[25:20]) : longint'(i[24:20]);
        if (sft && i[6:0] == 7'h1B && is64) v = longint'(i[24:20]);
        return v;
    endfunction

    task automatic check_outputs();
        logic [63:0] e32, e64;
        chk_eq("in_ready32", in_ready32, q.size() < 2);
        chk_eq("in_ready64", in_ready64, q.size() < 2);
        chk_eq("out_valid32", out_valid32, q.size() > 0);
        chk_eq("out_valid64", out_valid64, q.size() > 0);
        if (q.size() > 0) begin
            e32 = ref_imm(q[0].inst, 1'b0);
            e64 = ref_imm(q[0].inst, 1'b1);
            chk_eq("imm32", out_imm32, {32'b0, e32[31:0]});
            chk_eq("imm64", out_imm64, e64);
            e32 = e32 + q[0].pc;
            chk_eq("target32", out_target32, {32'b0, e32[31:0]});
            chk_eq("target64", out_target64, e64 + q[0].pc);
            chk_eq("fmt32", out_fmt32, ref_fmt(q[0].inst, 1'b0));
            chk_eq("fmt64", out_fmt64, ref_fmt(q[0].inst, 1'b1));
            chk_eq("inst32", out_inst32, q[0].inst);
            chk_eq("inst64", out_inst64, q[0].inst);
        end
    endtask

    // One clock: check current outputs, drive inputs, advance the scoreboard, step to next negedge.
    task automatic cycle(input bit v, input logic [31:0] i, input logic [63:0] p,
                         input bit ordy, input bit fl);
        bit acc, xfr;
        check_outputs();
        in_valid  = v;
        inst      = i;
        pc        = p;
        out_ready = ordy;
        flush     = fl;
        acc = v && (q.size() < 2);
        xfr = (q.size() > 0) && ordy;
        if (xfr) void'(q.pop_front());
        if (fl) q.delete();
        else if (acc) q.push_back('{i, p});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    endtask

    task automatic directed(input string tag, input logic [31:0] i, input logic [63:0] p,
                            input bit is64, input logic [63:0] e_imm,
                            input logic [63:0] e_tgt, input logic [2:0] e_fmt);
        idle(2);
        cycle(1'b1, i, p, 1'b1, 1'b0);
        if (is64) begin
            chk_eq({tag, "_valid"}, out_valid64, 1'b1);
            chk_eq({tag, "_imm"}, out_imm64, e_imm);
            chk_eq({tag, "_tgt"}, out_target64, e_tgt);
            chk_eq({tag, "_fmt"}, out_fmt64, e_fmt);
        end else begin
            chk_eq({tag, "_valid"}, out_valid32, 1'b1);
            chk_eq({tag, "_imm"}, out_imm32, e_imm);
            chk_eq({tag, "_tgt"}, out_target32, e_tgt);
            chk_eq({tag, "_fmt"}, out_fmt32, e_fmt);
        end
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [14] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h1B, 7'h23, 7'h63,
                                  7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F, 7'h00};
        logic [31:0] r = $urandom();
        logic [6:0]  op = ops[$urandom_range(0, 13)];
        if ($urandom_range(0, 7) == 0) op = r[6:0];
        return {r[31:7], op};
    endfunction

    initial begin
        logic [31:0] ia, ib, ic;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        inst = '0; pc = '0;
        @(negedge clk); @(negedge clk);
        chk_eq("rst_imm32", out_imm32, 0);
        chk_eq("rst_tgt64", out_target64, 0);
        chk_eq("rst_fmt32", out_fmt32, 0);
        chk_eq("rst_inst64", out_inst64, 0);
        rst = 1'b0;

        directed("i32", 32'hFFF00093, 64'h1000, 1'b0, 64'hFFFFFFFF, 64'h00000FFF, 3'd1);
        directed("s32", 32'hFE112E23, 64'h2000, 1'b0, 64'hFFFFFFFC, 64'h00001FFC, 3'd2);
        directed("b32", 32'hFE000CE3, 64'h100, 1'b0, 64'hFFFFFFF8, 64'h000000F8, 3'd3);
        directed("j32wrap", 32'h0080006F, 64'hFFFFFFFC, 1'b0, 64'h8, 64'h4, 3'd5);
        directed("j64wrap", 32'h0080006F, 64'hFFFFFFFFFFFFFFFC, 1'b1, 64'h8, 64'h4, 3'd5);
        directed("srai32", 32'h4030D093, 64'h0, 1'b0, 64'd3, 64'd3, 3'd1);
        directed("slli64", 32'h03F09093, 64'h0, 1'b1, 64'd63, 64'd63, 3'd1);
        directed("lui64", 32'h800000B7, 64'h10, 1'b1, 64'hFFFFFFFF80000000,
                 64'hFFFFFFFF80000010, 3'd4);
        directed("op32_ill", 32'h0010809B, 64'h40, 1'b0, 64'h0, 64'h40, 3'd7);
        directed("addiw64", 32'h0010809B, 64'h40, 1'b1, 64'h1, 64'h41, 3'd1);

        // Backpressure: three offers under stall, only two land, then drain in order.
        idle(2);
        ia = rand_inst(); ib = rand_inst(); ic = rand_inst();
        cycle(1'b1, ia, 64'h100, 1'b0, 1'b0);
        cycle(1'b1, ib, 64'h200, 1'b0, 1'b0);
        cycle(1'b1, ic, 64'h300, 1'b0, 1'b0);
        chk_eq("bp_in_ready", in_ready32, 1'b0);
        chk_eq("bp_head", out_inst32, ia);
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk_eq("bp_second", out_inst32, ib);
        chk_eq("bp_second_valid", out_valid32, 1'b1);
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk_eq("bp_drained", out_valid32, 1'b0);

        // Flush with both entries occupied.
        cycle(1'b1, ia, 64'h10, 1'b0, 1'b0);
        cycle(1'b1, ib, 64'h20, 1'b0, 1'b0);
        cycle(1'b1, ic, 64'h30, 1'b0, 1'b1);
        chk_eq("flush_valid", out_valid64, 1'b0);
        chk_eq("flush_ready", in_ready64, 1'b1);

        // Asynchronous reset while full.
        cycle(1'b1, ia, 64'h10, 1'b0, 1'b0);
        cycle(1'b1, ib, 64'h20, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_eq("arst_valid", out_valid32, 1'b0);
        chk_eq("arst_ready", in_ready32, 1'b1);
        chk_eq("arst_imm64", out_imm64, 0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic with varying pressure on both sides.
        for (int n = 0; n < 3000; n++) begin
            int  vp = (n / 250) % 4;
            bit  v  = $urandom_range(0, 3) < (vp + 1);
            bit  r  = $urandom_range(0, 3) >= (vp % 3);
            bit  f  = ($urandom_range(0, 63) == 0);
            logic [63:0] p = {$urandom(), $urandom()};
            cycle(v, rand_inst(), p, r, f);
        end
        idle(3);
        check_outputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
